// File: rtl/mac_stream_buffer.sv
// mac_stream_buffer: pipelined multiply / multiply-accumulate capture into an
// external memory, then a backpressured read-back of the captured block.
module mac_stream_buffer #(
    parameter int LOGDEPTH  = 6,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_a,
    input  logic [IN_WIDTH-1:0]  in_b,
    input  logic [LOGDEPTH-1:0]  cfg_len,
    input  logic                 cfg_signed,
    input  logic                 cfg_acc,
    input  logic                 flush,
    output logic                 wr_en,
    output logic [LOGDEPTH-1:0]  wr_addr,
    output logic [OUT_WIDTH-1:0] wr_data,
    output logic                 rd_en,
    output logic [LOGDEPTH-1:0]  rd_addr,
    input  logic [OUT_WIDTH-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int CW = LOGDEPTH + 1;
    localparam int PW = 2 * IN_WIDTH;

    if (OUT_WIDTH < PW) begin : g_width_check
        $error("OUT_WIDTH must be at least 2*IN_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, FILL, WAIT, READ} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]       n, len, ra, oidx, len_in;
    logic                sgn, acc;
    logic                accept, out_hs, push, pop_buf;
    logic                s1_v;
    logic [IN_WIDTH-1:0] s1_a, s1_b;
    logic [LOGDEPTH-1:0] s1_addr;
    logic [PW-1:0]       a_x, b_x, prod_full;
    logic [OUT_WIDTH-1:0] prod, wdata_nxt, sum;
    logic                rd_pend;
    logic [1:0]          cnt;
    logic                hd, tl;
    logic [OUT_WIDTH-1:0] sbuf [2];

    // A zero length field encodes a full 2^LOGDEPTH block.
    assign len_in = {(cfg_len == '0), cfg_len};

    assign in_ready = !rst && (state == IDLE || (state == FILL && n < len));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    assign a_x = sgn ? {{IN_WIDTH{s1_a[IN_WIDTH-1]}}, s1_a}
                     : {{IN_WIDTH{1'b0}}, s1_a};
    assign b_x = sgn ? {{IN_WIDTH{s1_b[IN_WIDTH-1]}}, s1_b}
                     : {{IN_WIDTH{1'b0}}, s1_b};
    assign prod_full = a_x * b_x;
    assign prod = sgn ? OUT_WIDTH'($signed(prod_full)) : OUT_WIDTH'(prod_full);
    assign wdata_nxt = acc ? sum + prod : prod;

    // Reads are throttled so the skid buffer can always absorb what is in flight.
    assign rd_en   = !rst && state == READ && ra < n
                     && (cnt + {1'b0, rd_pend}) < 2'd2;
    assign rd_addr = ra[LOGDEPTH-1:0];

    assign out_valid = (cnt != 2'd0) || rd_pend;
    assign out_data  = (cnt != 2'd0) ? sbuf[hd] : (rd_pend ? rd_data : '0);
    assign out_last  = out_valid && (oidx == n - CW'(1));
    assign out_hs    = out_valid && out_ready;
    assign push      = rd_pend && ((cnt != 2'd0) || !out_ready);
    assign pop_buf   = (cnt != 2'd0) && out_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (len_in == CW'(1)) ? WAIT : FILL;
            FILL: if (flush || (accept && n + CW'(1) == len)) state_nxt = WAIT;
            WAIT: if (!s1_v) state_nxt = READ;
            READ: if (out_hs && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n       <= '0;
            len     <= '0;
            sgn     <= 1'b0;
            acc     <= 1'b0;
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            sum     <= '0;
            ra      <= '0;
            oidx    <= '0;
            rd_pend <= 1'b0;
            cnt     <= 2'd0;
            hd      <= 1'b0;
            tl      <= 1'b0;
        end else begin
            state <= state_nxt;
            s1_v  <= accept;
            if (accept) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_addr <= (state == IDLE) ? '0 : n[LOGDEPTH-1:0];
            end
            wr_en <= s1_v;
            if (s1_v) begin
                wr_addr <= s1_addr;
                wr_data <= wdata_nxt;
                sum     <= wdata_nxt;
            end
            if (accept && state == IDLE) begin
                len <= len_in;
                sgn <= cfg_signed;
                acc <= cfg_acc;
                sum <= '0;
                n   <= CW'(1);
            end else if (accept) begin
                n <= n + CW'(1);
            end
            rd_pend <= rd_en;
            if (rd_en) ra <= ra + CW'(1);
            if (push) tl <= ~tl;
            if (pop_buf) hd <= ~hd;
            cnt <= cnt + {1'b0, push} - {1'b0, pop_buf};
            if (out_hs) oidx <= oidx + CW'(1);
            if (state == READ && state_nxt == IDLE) begin
                ra   <= '0;
                oidx <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) sbuf[tl] <= rd_data;
    end

endmodule
